// File: rtl/grid_sweep_ctrl.sv
// grid_sweep_ctrl: repeatedly sweeps a row-wide grid memory in place and
// clears every set cell with fewer than THRESH set 8-neighbours. A run ends
// on the first sweep that clears nothing, or when the round limit is hit.
module grid_sweep_ctrl #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned THRESH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned RND_W  = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [RND_W-1:0] max_rounds_i,
    output logic             mem_rd_en_o,
    output logic [AW-1:0]    mem_rd_addr_o,
    input  logic [WIDTH-1:0] mem_rd_data_i,
    output logic             mem_wr_en_o,
    output logic [AW-1:0]    mem_wr_addr_o,
    output logic [WIDTH-1:0] mem_wr_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] total_removed_o,
    output logic [RND_W-1:0] rounds_o
);

    localparam int unsigned   PW       = $clog2(WIDTH + 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CAP0  = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_EVAL  = 3'd4;
    localparam logic [2:0] S_ENDR  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    row_q, row_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [RND_W-1:0] rounds_q, rounds_d;
    logic [RND_W-1:0] max_rounds_q, max_rounds_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             not_last_c;
    logic [WIDTH-1:0] nxt_c;
    logic [WIDTH-1:0] new_c;
    logic [PW-1:0]    rem_c;
    logic [WIDTH+1:0] prev_ext, cur_ext, nxt_ext;
    logic [3:0]       ncnt;

    assign not_last_c = (row_q < LAST_ROW);

    // Row evaluation: neighbour count per column, clear weak set cells
    always_comb begin
        nxt_c    = not_last_c ? mem_rd_data_i : '0;
        prev_ext = {1'b0, prev_q, 1'b0};
        cur_ext  = {1'b0, cur_q, 1'b0};
        nxt_ext  = {1'b0, nxt_c, 1'b0};
        new_c    = cur_q;
        rem_c    = '0;
        ncnt     = '0;
        for (int c = 0; c < int'(WIDTH); c++) begin
            ncnt = 4'(prev_ext[c]) + 4'(prev_ext[c+1]) + 4'(prev_ext[c+2])
                 + 4'(cur_ext[c])                     + 4'(cur_ext[c+2])
                 + 4'(nxt_ext[c])  + 4'(nxt_ext[c+1]) + 4'(nxt_ext[c+2]);
            if (cur_q[c] && (32'(ncnt) < THRESH)) begin
                new_c[c] = 1'b0;
                rem_c    = rem_c + PW'(1);
            end
        end
    end

    // Next-state and register updates for the sweep sequencer
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        round_cnt_d  = round_cnt_q;
        total_d      = total_q;
        rounds_d     = rounds_q;
        max_rounds_d = max_rounds_q;
        timeout_d    = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    total_d      = '0;
                    rounds_d     = '0;
                    timeout_d    = 1'b0;
                    max_rounds_d = max_rounds_i;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                prev_d      = '0;
                round_cnt_d = '0;
                state_d     = S_CAP0;
            end
            S_CAP0: begin
                cur_d   = mem_rd_data_i;
                row_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                round_cnt_d = round_cnt_q + CNT_W'(rem_c);
                total_d     = total_q + CNT_W'(rem_c);
                prev_d      = new_c;
                cur_d       = nxt_c;
                if (not_last_c) begin
                    row_d   = row_q + AW'(1);
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ENDR;
                end
            end
            S_ENDR: begin
                rounds_d = (rounds_q == '1) ? rounds_q : rounds_q + RND_W'(1);
                if (round_cnt_q == '0) begin
                    state_d = S_DONE;
                end else if ((max_rounds_q != '0) &&
                             (({1'b0, rounds_q} + (RND_W+1)'(1)) == {1'b0, max_rounds_q})) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_CAP0) || (state_d == S_FETCH) ||
                 (state_d == S_EVAL) || (state_d == S_ENDR);
        done_d = (state_q == S_DONE);
    end

    // State and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            prev_q       <= '0;
            cur_q        <= '0;
            round_cnt_q  <= '0;
            total_q      <= '0;
            rounds_q     <= '0;
            max_rounds_q <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            round_cnt_q  <= round_cnt_d;
            total_q      <= total_d;
            rounds_q     <= rounds_d;
            max_rounds_q <= max_rounds_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Memory port: read row 0 in LOAD, row r+1 in FETCH, write row r in EVAL
    always_comb begin
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;
        mem_wr_en_o   = 1'b0;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        case (state_q)
            S_LOAD: mem_rd_en_o = 1'b1;
            S_FETCH: begin
                if (not_last_c) begin
                    mem_rd_en_o   = 1'b1;
                    mem_rd_addr_o = row_q + AW'(1);
                end
            end
            S_EVAL: begin
                mem_wr_en_o   = 1'b1;
                mem_wr_addr_o = row_q;
                mem_wr_data_o = new_c;
            end
            default: ;
        endcase
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign timeout_o       = timeout_q;
    assign total_removed_o = total_q;
    assign rounds_o        = rounds_q;

endmodule

// File: tb/tb_grid_sweep_ctrl.sv
// Bench for grid_sweep_ctrl: three instances (3x3, 10x10, 1x3) with
// behavioural memories; expected run results queued by stimulus and
// checked by a monitor when done pulses.
module tb_grid_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start3, start10, start1;
    logic [15:0] max_rounds;

    logic        rd_en3, wr_en3, busy3, done3, to3;
    logic [1:0]  rd_addr3, wr_addr3;
    logic [2:0]  rd_data3, wr_data3;
    logic [31:0] tot3;
    logic [15:0] rnd3;

    logic        rd_en10, wr_en10, busy10, done10, to10;
    logic [3:0]  rd_addr10, wr_addr10;
    logic [9:0]  rd_data10, wr_data10;
    logic [31:0] tot10;
    logic [15:0] rnd10;

    logic        rd_en1, wr_en1, busy1, done1, to1;
    logic [0:0]  rd_addr1, wr_addr1;
    logic [2:0]  rd_data1, wr_data1;
    logic [31:0] tot1;
    logic [15:0] rnd1;

    logic [2:0] m3 [3];
    logic [9:0] m10 [10];
    logic [2:0] m1 [1];

    longint cyc = 0;
    int     wr10_cnt = 0;
    int     wr10_nz = 0;

    typedef struct {
        int     id;
        int     rnd;
        longint tot;
        int     to;
        longint done_cyc;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    grid_sweep_ctrl #(.WIDTH(3), .DEPTH(3), .THRESH(4), .CNT_W(32), .RND_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .max_rounds_i(max_rounds),
        .mem_rd_en_o(rd_en3), .mem_rd_addr_o(rd_addr3), .mem_rd_data_i(rd_data3),
        .mem_wr_en_o(wr_en3), .mem_wr_addr_o(wr_addr3), .mem_wr_data_o(wr_data3),
        .busy_o(busy3), .done_o(done3), .timeout_o(to3),
        .total_removed_o(tot3), .rounds_o(rnd3)
    );

    grid_sweep_ctrl #(.WIDTH(10), .DEPTH(10), .THRESH(4), .CNT_W(32), .RND_W(16)) u10 (
        .clk(clk), .rst_n(rst_n), .start_i(start10), .max_rounds_i(max_rounds),
        .mem_rd_en_o(rd_en10), .mem_rd_addr_o(rd_addr10), .mem_rd_data_i(rd_data10),
        .mem_wr_en_o(wr_en10), .mem_wr_addr_o(wr_addr10), .mem_wr_data_o(wr_data10),
        .busy_o(busy10), .done_o(done10), .timeout_o(to10),
        .total_removed_o(tot10), .rounds_o(rnd10)
    );

    grid_sweep_ctrl #(.WIDTH(3), .DEPTH(1), .THRESH(4), .CNT_W(32), .RND_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .max_rounds_i(max_rounds),
        .mem_rd_en_o(rd_en1), .mem_rd_addr_o(rd_addr1), .mem_rd_data_i(rd_data1),
        .mem_wr_en_o(wr_en1), .mem_wr_addr_o(wr_addr1), .mem_wr_data_o(wr_data1),
        .busy_o(busy1), .done_o(done1), .timeout_o(to1),
        .total_removed_o(tot1), .rounds_o(rnd1)
    );

    // Behavioural memories: registered read, write at the edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rd_en3) rd_data3 <= m3[rd_addr3];
        if (rd_en10) rd_data10 <= m10[rd_addr10];
        if (rd_en1) rd_data1 <= m1[0];
        if (wr_en3) m3[wr_addr3] = wr_data3;
        if (wr_en10) begin
            m10[wr_addr10] = wr_data10;
            wr10_cnt = wr10_cnt + 1;
            if (wr_data10 != 10'd0) wr10_nz = wr10_nz + 1;
        end
        if (wr_en1) m1[0] = wr_data1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic score(input int id, input longint r, input longint t, input longint to);
        exp_t e;
        chk($sformatf("pending_expectations_u%0d", id), sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_source", id, e.id);
            chk($sformatf("rounds_u%0d", id), r, e.rnd);
            chk($sformatf("total_removed_u%0d", id), t, e.tot);
            chk($sformatf("timeout_u%0d", id), to, e.to);
            chk($sformatf("done_cycle_u%0d", id), cyc, e.done_cyc);
        end
    endtask

    // Monitor: results on done, plus memory-port sanity every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (done3)  score(0, rnd3, tot3, to3);
            if (done10) score(1, rnd10, tot10, to10);
            if (done1)  score(2, rnd1, tot1, to1);
            if (rd_en3) chk("u3_rd_addr_range", rd_addr3 < 2'd3, 1);
            if (wr_en3) begin
                chk("u3_wr_addr_range", wr_addr3 < 2'd3, 1);
                chk("u3_rw_same_addr", rd_en3 && (rd_addr3 == wr_addr3), 0);
            end
            if (rd_en10) chk("u10_rd_addr_range", rd_addr10 < 4'd10, 1);
            if (wr_en10) begin
                chk("u10_wr_addr_range", wr_addr10 < 4'd10, 1);
                chk("u10_rw_same_addr", rd_en10 && (rd_addr10 == wr_addr10), 0);
            end
            if (rd_en1) chk("u1_rd_addr", rd_addr1, 0);
            if (wr_en1) chk("u1_wr_addr", wr_addr1, 0);
        end
    end

    task automatic pulse_start(input int id, input int mr);
        @(negedge clk);
        max_rounds = 16'(mr);
        case (id)
            0:       start3 = 1'b1;
            1:       start10 = 1'b1;
            default: start1 = 1'b1;
        endcase
        @(negedge clk);
        start3 = 1'b0;
        start10 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic run(input int id, input int mr, input int r, input longint t,
                       input int to, input int lat);
        exp_t e;
        pulse_start(id, mr);
        e.id = id;
        e.rnd = r;
        e.tot = t;
        e.to = to;
        e.done_cyc = cyc + longint'(lat);
        sb.push_back(e);
    endtask

    task automatic wait_done(input int id, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (id == 0) ? done3 : (id == 1) ? done10 : done1;
        end
        chk($sformatf("done_within_budget_u%0d", id), seen, 1);
        @(negedge clk);
    endtask

    task automatic load3_ones();
        for (int i = 0; i < 3; i++) m3[i] = 3'b111;
    endtask

    task automatic chk_u3_reset(input string tag);
        chk({tag, "_busy"}, busy3, 0);
        chk({tag, "_done"}, done3, 0);
        chk({tag, "_timeout"}, to3, 0);
        chk({tag, "_total"}, tot3, 0);
        chk({tag, "_rounds"}, rnd3, 0);
        chk({tag, "_rd_en"}, rd_en3, 0);
        chk({tag, "_wr_en"}, wr_en3, 0);
        chk({tag, "_rd_addr"}, rd_addr3, 0);
        chk({tag, "_wr_addr"}, wr_addr3, 0);
        chk({tag, "_wr_data"}, wr_data3, 0);
    endtask

    initial begin
        int     base_cnt, base_nz;
        logic   seen;
        logic [9:0] acc;
        rst_n = 1'b0;
        start3 = 1'b0;
        start10 = 1'b0;
        start1 = 1'b0;
        max_rounds = 16'd0;
        load3_ones();
        for (int i = 0; i < 10; i++) m10[i] = 10'd0;
        m1[0] = 3'b000;
        repeat (3) @(negedge clk);

        // Reset values
        chk_u3_reset("reset_u3");
        chk("reset_u10_busy", busy10, 0);
        chk("reset_u10_wr_en", wr_en10, 0);
        chk("reset_u1_rd_en", rd_en1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3x3 all ones, round limit 1
        load3_ones();
        run(0, 1, 1, 4, 1, 10);
        wait_done(0, 30);
        chk("lim1_row0", m3[0], 3'b010);
        chk("lim1_row1", m3[1], 3'b111);
        chk("lim1_row2", m3[2], 3'b010);
        repeat (3) @(negedge clk);
        chk("lim1_timeout_held", to3, 1);
        chk("lim1_rounds_held", rnd3, 1);
        chk("lim1_total_held", tot3, 4);

        // 3x3 all ones, unlimited; timeout must clear on start
        load3_ones();
        run(0, 0, 3, 9, 0, 28);
        chk("start_clears_timeout", to3, 0);
        chk("busy_after_start", busy3, 1);
        wait_done(0, 40);
        chk("full_row0", m3[0], 3'b000);
        chk("full_row1", m3[1], 3'b000);
        chk("full_row2", m3[2], 3'b000);
        chk("busy_after_done", busy3, 0);

        // 10x10 all zero: one round, ten zero writes
        for (int i = 0; i < 10; i++) m10[i] = 10'd0;
        base_cnt = wr10_cnt;
        base_nz = wr10_nz;
        run(1, 0, 1, 0, 0, 24);
        wait_done(1, 40);
        chk("zero_grid_writes", wr10_cnt - base_cnt, 10);
        chk("zero_grid_nonzero_writes", wr10_nz - base_nz, 0);

        // 10x10 single isolated cell at row 4 column 7
        for (int i = 0; i < 10; i++) m10[i] = 10'd0;
        m10[4] = 10'b0010000000;
        run(1, 0, 2, 1, 0, 47);
        wait_done(1, 70);
        acc = 10'd0;
        for (int i = 0; i < 10; i++) acc = acc | m10[i];
        chk("single_cell_final_or", acc, 0);

        // DEPTH=1, row 111
        m1[0] = 3'b111;
        run(2, 0, 2, 3, 0, 11);
        wait_done(2, 30);
        chk("depth1_final_row", m1[0], 0);

        // Reset asserted during EVAL of round 1
        load3_ones();
        pulse_start(0, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (wr_en3) seen = 1'b1;
            else @(negedge clk);
        end
        chk("reached_eval", seen, 1);
        rst_n = 1'b0;
        #1;
        chk_u3_reset("midrun_reset_u3");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_low_wr_en", wr_en3, 0);
            chk("reset_low_busy", busy3, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Re-start after reset
        load3_ones();
        run(0, 0, 3, 9, 0, 28);
        wait_done(0, 40);
        chk("restart_row1", m3[1], 3'b000);

        // Start pulses while busy are ignored
        load3_ones();
        run(0, 0, 3, 9, 0, 28);
        repeat (5) @(negedge clk);
        chk("busy_mid_run", busy3, 1);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (10) @(negedge clk);
        start3 = 1'b1;
        max_rounds = 16'd1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done(0, 40);
        chk("ignored_start_row1", m3[1], 3'b000);
        repeat (3) @(negedge clk);
        chk("ignored_start_idle", busy3, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_sweep_ctrl.md
# grid_sweep_ctrl

Sequencer for the iterative grid-erosion computation. It owns a row-wide grid memory and repeatedly sweeps it in place, top to bottom, one row at a time. In each sweep it clears every set cell that has fewer than THRESH set 8-neighbours. Sweeps repeat until one removes nothing or a round limit is reached, and the block reports total removals and the round count.

## Interface
- WIDTH, 10, cells per row (memory word width)
- DEPTH, 10, rows (memory depth); AW = max(1, clog2(DEPTH))
- THRESH, 4, a set cell survives only with ≥THRESH set neighbours
- CNT_W, 32, total_removed width; must satisfy 2^CNT_W > WIDTH*DEPTH
- RND_W, 16, rounds / max_rounds width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- max_rounds  in  RND_W  round limit; 0 = unlimited; sampled at start
- mem_rd_en / mem_rd_addr  out  1 / AW  read request; data valid the cycle after
- mem_rd_data  in  WIDTH  read data, bit c = column c
- mem_wr_en / mem_wr_addr / mem_wr_data  out  1 / AW / WIDTH  write port
- busy  out  1  high from LOAD of round 1 through ENDR of the last round
- done  out  1  one-cycle pulse at run end
- timeout  out  1  set at done if the run stopped on max_rounds; held until next start
- total_removed  out  CNT_W  cells cleared this run; held after done
- rounds  out  RND_W  rounds executed, including the final zero-removal round; held after done

## Operation
- States: IDLE, LOAD, CAP0, FETCH, EVAL, ENDR, DONE. Row index r is 0..DEPTH-1.
- IDLE: if start, clear total_removed, rounds, timeout; latch max_rounds; go to LOAD. start is ignored in every other state.
- LOAD: rd_en, addr 0; prev<=0; round_cnt<=0; go to CAP0.
- CAP0: cur<=mem_rd_data; r<=0; go to FETCH.
- FETCH: if r<DEPTH-1, rd_en with addr r+1; otherwise no read. Go to EVAL.
- EVAL: nxt = (r<DEPTH-1) ? mem_rd_data : 0.
  - new = evaluate(prev, cur, nxt). Write new to row r.
  - rem = popcount(cur & ~new). round_cnt += rem; total_removed += rem.
  - prev<=new; cur<=nxt.
  - If r==DEPTH-1, go to ENDR; otherwise r++ and go to FETCH.
- Evaluation rule:
  - Out-of-grid neighbours count as 0.
  - prev is the already-updated row r-1; nxt is the original row r+1.
  - Within a row, all cells use the pre-update cur. There is no left-to-right dependency.
  - A cell with cur=1 and neighbour count <THRESH becomes 0. All other cells are unchanged. 0 cells never become 1.
- ENDR: rounds++ (saturating).
  - If round_cnt==0, go to DONE.
  - Else if max_rounds≠0 and rounds+1==max_rounds, set timeout and go to DONE.
  - Otherwise go to LOAD.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- Final grid contents are order-independent: the unique maximal subset in which every cell has ≥THRESH neighbours. total_removed is therefore independent of sweep order. rounds is as defined by this schedule.
- Reset mid-run: all state and outputs return to reset values immediately, with no further memory access. Memory contents may be partially updated; the caller reloads.

## Timing
- Reset values: busy 0, done 0, timeout 0, total_removed 0, rounds 0, mem_rd_en 0, mem_wr_en 0, mem_rd_addr 0, mem_wr_addr 0, mem_wr_data 0.
- One round = 2*DEPTH+3 cycles.
- done pulses N*(2*DEPTH+3)+1 cycles after the edge that samples start in IDLE, where N = rounds.
- Read and write never target the same address in one cycle.
- Row r+1 is always read before row r+1 is written in that round.
- mem_wr_en is asserted exactly DEPTH cycles per round. Addresses are never ≥DEPTH.
- Outputs are registered, except mem_* which are combinational from state and registers.

## Test plan
- 3x3 all ones, THRESH 4, max_rounds 0:
  - after round 1 the memory is 010/111/010 (4 removed); round 2 removes 5; round 3 removes 0.
  - Required: rounds=3, total_removed=9, timeout=0, done 28 cycles after start.
- Same grid with max_rounds=1: timeout=1, rounds=1, total_removed=4, memory 010/111/010.
- 10x10 all zero: rounds=1, total_removed=0, done 24 cycles after start, 10 writes of 0.
- 10x10 with a single cell at row 4 column 7: rounds=2, total_removed=1, final memory all zero.
- DEPTH=1, WIDTH=3, row 111: rounds=2, total_removed=3; mem_rd_addr never exceeds 0.
- Reset and start handling:
  - rst_n low during EVAL of round 1: all outputs at reset values on the next edge, no mem_wr_en while low.
  - start pulsed while busy: ignored, with results identical to an undisturbed run.
  - A re-start after reset completes normally.
